// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - RV32I integer register file with multi-port read, bypass, scoreboard and soft clear
//
// Purpose: NRP-read / 1-write register file sitting between ID and WB. Reads are
// combinational with optional same-cycle write forwarding. A pending-write
// scoreboard flags sources that must stall. A soft-clear request zeroes the array
// one register per cycle while reporting every read port busy.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-low
//   we        write-back enable
//   waddr     write-back register index
//   wdata     write-back data
//   re        per-port read enable
//   raddr     read indices, port i = raddr[i*AW +: AW]
//   rdata     read data, port i = rdata[i*XLEN +: XLEN]
//   rbusy     port i source has a pending write that is not forwarded
//   rstall    OR of rbusy
//   issue_v   instruction issued, its destination becomes pending
//   issue_rd  destination of the issued instruction
//   clr       soft-clear request pulse
//   ready     low while a soft clear is in progress

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRP    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRP-1:0]      re,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  output logic                rstall,
  input  logic                issue_v,
  input  logic [AW-1:0]       issue_rd,
  input  logic                clr,
  output logic                ready
);

  typedef enum logic {RUN, CLEAR} state_t;

  localparam logic [AW:0]   NREG_X   = (AW+1)'(NREG);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  state_t            state;
  logic [AW-1:0]     idx;
  logic [XLEN-1:0]   regs [NREG];
  logic [NREG-1:0]   busy;

  logic              run_upd;
  logic              wr_en;
  logic              wb_clr;
  logic              iss_en;

  // Indices at or beyond NREG are treated as non-existent registers.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_X);
  endfunction

  // The cycle that samples clr ignores write-back and issue.
  assign run_upd = (state == RUN) && !clr;
  assign wr_en   = run_upd && we && (waddr != '0) && in_range(waddr);
  assign wb_clr  = run_upd && we && in_range(waddr);
  assign iss_en  = run_upd && issue_v && (issue_rd != '0) && in_range(issue_rd);

  // Clear sequencer: walks idx from 1 to NREG-1, one register per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      idx   <= FIRST_IDX;
      ready <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (clr) begin
            state <= CLEAR;
            idx   <= FIRST_IDX;
            ready <= 1'b0;
          end
        end
        CLEAR: begin
          if (idx == LAST_IDX) begin
            state <= RUN;
            idx   <= FIRST_IDX;
            ready <= 1'b1;
          end else begin
            idx <= idx + FIRST_IDX;
          end
        end
        default: begin
          state <= RUN;
          idx   <= FIRST_IDX;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Register array; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[idx] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Scoreboard: the set is applied after the clear so a same-cycle
  // issue to the written register leaves it pending for the new producer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else if (state == RUN) begin
      if (clr) begin
        busy <= '0;
      end else begin
        if (wb_clr) begin
          busy[waddr] <= 1'b0;
        end
        if (iss_en) begin
          busy[issue_rd] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    a     = '0;
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < NRP; p++) begin
      a = raddr[p*AW +: AW];
      if (state == CLEAR) begin
        rbusy[p] = 1'b1;
      end else if (!re[p] || (a == '0) || !in_range(a)) begin
        rbusy[p] = 1'b0;
      end else if ((BYPASS != 0) && we && (waddr == a)) begin
        rdata[p*XLEN +: XLEN] = wdata;
      end else begin
        rdata[p*XLEN +: XLEN] = regs[a];
        rbusy[p]              = busy[a];
      end
    end
  end

  assign rstall = |rbusy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb against a behavioural model

module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;

  logic                clk;
  logic                rst;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRP-1:0]      re;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                rstall;
  logic                issue_v;
  logic [AW-1:0]       issue_rd;
  logic                clr;
  logic                ready;

  int checks;
  int errors;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rstall(rstall),
    .issue_v(issue_v), .issue_rd(issue_rd), .clr(clr), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state plus a count of clear cycles left.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  int              clear_left;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    clear_left = 0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (clr) begin
      clear_left = NREG - 1;
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && waddr != 0) m_regs[waddr] = wdata;
      if (we) m_busy[waddr] = 1'b0;
      if (issue_v && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [XLEN-1:0] ed;
    logic            eb;
    logic            any_b;
    logic [AW-1:0]   a;
    any_b = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      a = raddr[p*AW +: AW];
      if (!rst)                     begin ed = '0;        eb = 1'b0;      end
      else if (clear_left > 0)      begin ed = '0;        eb = 1'b1;      end
      else if (!re[p] || a == 0)    begin ed = '0;        eb = 1'b0;      end
      else if (we && waddr == a)    begin ed = wdata;     eb = 1'b0;      end
      else                          begin ed = m_regs[a]; eb = m_busy[a]; end
      any_b = any_b | eb;
      chk($sformatf("cmp_rdata%0d", p), rdata[p*XLEN +: XLEN], ed);
      chk($sformatf("cmp_rbusy%0d", p), {31'd0, rbusy[p]}, {31'd0, eb});
    end
    chk("cmp_rstall", {31'd0, rstall}, {31'd0, any_b});
    chk("cmp_ready", {31'd0, ready}, (!rst || clear_left == 0) ? 32'd1 : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; re = 0; raddr = 0;
    issue_v = 0; issue_rd = 0; clr = 0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    re    = 2'b11;
    raddr = {a1, a0};
  endtask

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle();
    set_rd(5'd5, 5'd0);
    @(negedge clk);
    chk("reset_rdata", rdata[31:0], 32'h0);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    tick();
    rst = 1'b1;

    // Write then read x5 and x0.
    idle(); we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    tick();
    idle(); set_rd(5'd5, 5'd0);
    @(negedge clk);
    chk("t1_rdata0", rdata[31:0], 32'hDEADBEEF);
    chk("t1_rdata1", rdata[63:32], 32'h0);
    chk("t1_rstall", {31'd0, rstall}, 32'd0);
    tick();

    // Same-cycle write forwarding.
    idle(); we = 1; waddr = 7; wdata = 32'h11111111;
    tick();
    idle(); we = 1; waddr = 7; wdata = 32'h12345678; set_rd(5'd7, 5'd5);
    @(negedge clk);
    chk("t2_bypass", rdata[31:0], 32'h12345678);
    chk("t2_rbusy0", {31'd0, rbusy[0]}, 32'd0);
    chk("t2_port1", rdata[63:32], 32'hDEADBEEF);
    tick();

    // Scoreboard set, forwarded write-back, then cleared.
    idle(); issue_v = 1; issue_rd = 3;
    tick();
    idle(); set_rd(5'd3, 5'd0);
    @(negedge clk);
    chk("t3_busy", {31'd0, rbusy[0]}, 32'd1);
    chk("t3_rstall", {31'd0, rstall}, 32'd1);
    tick();
    idle(); we = 1; waddr = 3; wdata = 32'h55; set_rd(5'd3, 5'd0);
    @(negedge clk);
    chk("t3_wb_data", rdata[31:0], 32'h55);
    chk("t3_wb_busy", {31'd0, rbusy[0]}, 32'd0);
    tick();
    idle(); set_rd(5'd3, 5'd0);
    @(negedge clk);
    chk("t3_after", {31'd0, rbusy[0]}, 32'd0);
    tick();

    // Same-cycle issue and write-back of x9: issue wins. Issue to x0 is ignored.
    idle(); issue_v = 1; issue_rd = 9; we = 1; waddr = 9; wdata = 32'h99;
    tick();
    idle(); issue_v = 1; issue_rd = 0; set_rd(5'd9, 5'd0);
    @(negedge clk);
    chk("t4_setwins", {31'd0, rbusy[0]}, 32'd1);
    chk("t4_data", rdata[31:0], 32'h99);
    tick();
    idle(); set_rd(5'd0, 5'd9);
    @(negedge clk);
    chk("t4_x0", {31'd0, rbusy[0]}, 32'd0);
    tick();

    // Fill, then soft clear with a write attempt in the middle.
    for (int i = 1; i < NREG; i++) begin
      idle(); we = 1; waddr = AW'(i); wdata = i;
      tick();
    end
    idle(); clr = 1; set_rd(5'd4, 5'd9);
    @(negedge clk);
    chk("t5_ready_pre", {31'd0, ready}, 32'd1);
    tick();
    clr = 0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready) break;
      cnt++;
      chk("t5_rstall", {31'd0, rstall}, 32'd1);
      we = (cnt == 15); waddr = 4; wdata = 32'hFFFF;
    end
    chk("t5_len", cnt, 32'd31);
    we = 0;
    for (int i = 0; i < NREG; i += 2) begin
      set_rd(AW'(i), AW'(i + 1));
      @(negedge clk);
      chk("t5_zero0", rdata[31:0], 32'h0);
      chk("t5_zero1", rdata[63:32], 32'h0);
      chk("t5_nobusy", {30'd0, rbusy}, 32'd0);
    end

    // Reset in the middle of a clear.
    tick();
    idle(); clr = 1;
    tick();
    clr = 0;
    for (int c = 0; c < 10; c++) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_ready", {31'd0, ready}, 32'd1);
    chk("t6_rstall", {31'd0, rstall}, 32'd0);
    tick();
    rst = 1'b1;
    idle(); we = 1; waddr = 4; wdata = 32'hA5;
    tick();
    idle(); set_rd(5'd4, 5'd0);
    @(negedge clk);
    chk("t6_x4", rdata[31:0], 32'hA5);
    chk("t6_busy", {31'd0, rbusy[0]}, 32'd0);
    tick();

    // Randomized traffic with small address ranges to hit bypass and scoreboard hazards.
    for (int n = 0; n < 3000; n++) begin
      we       = ($urandom_range(0, 2) != 0);
      waddr    = AW'($urandom_range(0, 7));
      wdata    = $urandom;
      re       = NRP'($urandom);
      raddr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      issue_v  = ($urandom_range(0, 1) != 0);
      issue_rd = AW'($urandom_range(0, 7));
      clr      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) raddr[AW-1:0] = waddr;
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
